chan_interleave_mux: RTL

//  Parametrised, registered round-robin interleaver. It multiplexes NUM_CH

---
 rtl/chan_interleave_mux_pkg.sv | 18 +
 rtl/chan_interleave_mux_rr_pick.sv | 33 +++
 rtl/chan_interleave_mux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/chan_interleave_mux_pkg.sv
// Shared constants and channel-index helpers for the round-robin interleaver.
// Imported by the channel picker and the interleaver top.
package interleave_pkg;

    localparam int MODE_STRICT = 0;
    localparam int MODE_SKIP   = 1;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_CH  = 12;

    // Successor channel with an explicit wrap at num_ch, not at a power of two.
    function automatic int unsigned next_ch(input int unsigned idx, input int unsigned num_ch);
        if (idx >= num_ch - 1)
            return 0;
        return idx + 1;
    endfunction

endpackage

// File: rtl/chan_interleave_mux_rr_pick.sv
// Combinational cyclic priority encoder: first requesting channel at or after
// base, wrapping from NUM_CH-1 back to 0.
module rr_pick
    import interleave_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  base,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    localparam int unsigned N = NUM_CH;

    always_comb begin
        int unsigned idx;
        gnt_idx = base;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(base) + k;
            if (idx >= N)
                idx = idx - N;
            if (!gnt_any && req[idx[SEL_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/chan_interleave_mux.sv
// Registered round-robin interleaver: NUM_CH valid/ready byte streams onto one
// output stream, driven by a self-sequencing channel pointer.
module chan_interleave_mux
    import interleave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int MODE   = MODE_STRICT,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         ptr
);

    logic [SEL_W-1:0]  ptr_q,       ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic              out_last_q,  out_last_d;

    logic [SEL_W-1:0]  grant;
    logic              grant_any;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] word;

    // rst gates load so in_ready stays low for the whole reset window.
    assign load = en & ~clr & ~rst & (~out_valid_q | out_ready);
    assign xfer = load & grant_any;

    if (MODE == MODE_SKIP) begin : g_skip
        rr_pick #(
            .NUM_CH (NUM_CH),
            .SEL_W  (SEL_W)
        ) u_pick (
            .req     (in_valid),
            .base    (ptr_q),
            .gnt_idx (grant),
            .gnt_any (grant_any)
        );
    end else begin : g_strict
        assign grant     = ptr_q;
        assign grant_any = in_valid[ptr_q];
    end

    // Equality-decoded mux: only the granted lane can reach the output word.
    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant == SEL_W'(c))
                word = in_data[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            in_ready[c] = load && (grant == SEL_W'(c));
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        if (clr) begin
            ptr_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_ch_d    = '0;
            out_last_d  = 1'b0;
        end else if (load) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = word;
                out_ch_d    = grant;
                out_last_d  = (32'(grant) == NUM_CH - 1);
                ptr_d       = SEL_W'(next_ch(32'(grant), NUM_CH));
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready) begin
            // en=0 drain: the held word leaves on this handshake.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign ptr       = ptr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule
